// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the ready-handshaked instruction-memory
// port and the IF/ID register, with one delay slot for ID-resolved redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        id_shouldStall,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_jumpOrBranchPc,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic [31:0] debug_pc,
  output logic        debug_redirectPending
);

  typedef enum logic {SEQ, REDIRECT_PENDING} state_t;

  state_t      state, stateNext;
  logic [31:0] pc_p0, pcNext;
  logic [31:0] pendingTarget_p0, pendingTargetNext;
  logic [31:0] pc4_p1, pc4Next;
  logic [31:0] instr_p1, instrNext;
  logic        vld_p1, vldNext;
  logic        redirect;
  logic [31:0] pcPlus4;

  function automatic logic [31:0] alignTarget(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

  assign pcPlus4  = pc_p0 + 32'd4;
  // Bubbles in IF/ID carry no real branch, so they can never redirect.
  assign redirect = id_shouldJumpOrBranch & vld_p1 & ~id_shouldStall;

  always_comb begin
    stateNext         = state;
    pcNext            = pc_p0;
    pendingTargetNext = pendingTarget_p0;
    pc4Next           = pc4_p1;
    instrNext         = instr_p1;
    vldNext           = vld_p1;
    if (id_shouldStall) begin
      // Hold everything; the same address is re-presented next cycle.
    end else if (imem_ready) begin
      pc4Next   = pcPlus4;
      instrNext = imem_data;
      vldNext   = 1'b1;
      if (redirect) begin
        pcNext    = alignTarget(id_jumpOrBranchPc);
        stateNext = SEQ;
      end else if (state == REDIRECT_PENDING) begin
        pcNext    = pendingTarget_p0;
        stateNext = SEQ;
      end else begin
        pcNext = pcPlus4;
      end
    end else begin
      // Delay slot not yet fetched: remember the target until it is.
      instrNext = NOP_INSTR;
      vldNext   = 1'b0;
      if (redirect) begin
        pendingTargetNext = alignTarget(id_jumpOrBranchPc);
        stateNext         = REDIRECT_PENDING;
      end
    end
  end

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= SEQ;
      pc_p0            <= RESET_PC;
      pendingTarget_p0 <= 32'd0;
      pc4_p1           <= 32'd0;
      instr_p1         <= NOP_INSTR;
      vld_p1           <= 1'b0;
    end else begin
      state            <= stateNext;
      pc_p0            <= pcNext;
      pendingTarget_p0 <= pendingTargetNext;
      pc4_p1           <= pc4Next;
      instr_p1         <= instrNext;
      vld_p1           <= vldNext;
    end
  end

  assign imem_req              = ~rst;
  assign imem_addr             = pc_p0;
  assign id_pc_4               = pc4_p1;
  assign id_instruction        = instr_p1;
  assign id_valid              = vld_p1;
  assign debug_pc              = pc_p0;
  assign debug_redirectPending = (state == REDIRECT_PENDING);

endmodule
